dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256: data memory size in 32-bit words; power of two, minimum 4.
REQ-002 Parameter LATENCY, default 2: wait cycles between request accept and response; minimum 1, maximum 15.
REQ-003 clk  input  1: single clock; all state changes on rising edge.
REQ-004 rst  input  1: reset, asynchronous, active-low.
REQ-005 req  input  1: MEM-stage access valid (load or store).
REQ-006 we  input  1: 1 = store, 0 = load; sampled with req.
REQ-007 addr  input  32: byte address (aluoutM).
REQ-008 wdata  input  32: store data (writedataM).
REQ-009 rdata  output  32: load data, registered.
REQ-010 ready  output  1: response valid, one-cycle pulse.
REQ-011 stall  output  1: request pending; feeds hazard unit to freeze F/D/E/M.
REQ-012 err  output  1: misaligned-access pulse; present only with macro (REQ-027).

Function
REQ-013 FSM states IDLE, WAIT, RESP; IDLE after reset.
REQ-014 IDLE: req=1 latches we/addr/wdata, loads counter with LATENCY-1, moves to WAIT; req=0 stays IDLE.
REQ-015 WAIT: counter decrements each cycle; at counter 0 performs access and moves to RESP.
REQ-016 Access: word index = addr[log2(DEPTH)+1:2]; upper address bits ignored (wrap-around, no error).
REQ-017 Store writes latched wdata to array at end of WAIT; rdata holds previous value.
REQ-018 Load registers array word into rdata at end of WAIT; rdata holds until next load completes.
REQ-019 RESP: ready=1 for exactly one cycle, then IDLE unconditionally.
REQ-020 stall = req AND NOT ready, combinational; request-accept to ready = LATENCY+1 cycles.
REQ-021 Inputs changing during WAIT/RESP are ignored; only latched copies are used.
REQ-022 req in RESP cycle is not accepted; it is accepted in the following IDLE cycle (back-to-back spacing LATENCY+2 cycles).
REQ-023 Load after store to same word returns the stored value.

Reset
REQ-024 rst low forces state IDLE, counter 0, rdata 0, ready 0, err 0, latched registers 0, immediately and independent of clk.
REQ-025 Reset during WAIT discards pending access: no array write occurs; array contents are otherwise preserved and are not cleared by reset.
REQ-026 After rst rises, first req is accepted on the first rising edge with req=1.

Configuration
REQ-027 Macro DMEM_MISALIGN_CHECK_EN defined: in IDLE, if addr[1:0]!=0 when req is accepted, the request proceeds through WAIT/RESP with normal timing; the store is suppressed; rdata is forced to 0; err=1 in the same cycle as ready.
REQ-028 Macro DMEM_MISALIGN_CHECK_EN undefined: addr[1:0] ignored, err port absent, all accesses complete normally.

Verification
REQ-029 LATENCY=2, store addr=0x10 wdata=0xDEADBEEF, then load addr=0x10 -> ready 3 cycles after each accept; rdata=0xDEADBEEF; stall high until ready.
REQ-030 DEPTH=256, store 0x12345678 at addr=0x404, load addr=0x004 -> rdata=0x12345678 (wrap).
REQ-031 Store 0xAAAA5555 at 0x20, rst low during WAIT, release, load 0x20 -> old contents returned; ready not pulsed for aborted access; all outputs 0 during reset.
REQ-032 req held high continuously for two loads -> accepts spaced 4 cycles (LATENCY=2); ready never high two consecutive cycles.
REQ-033 With DMEM_MISALIGN_CHECK_EN defined, store 0x1 at addr=0x22, then load 0x20 -> first access: err=1 with ready, rdata=0; load returns the unmodified prior word.
REQ-034 LATENCY=1, load with inputs toggled during WAIT -> rdata reflects the addr latched at accept.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for a pipelined core: accepts one access, waits LATENCY
// cycles, then pulses ready. Optional misaligned-access check via DMEM_MISALIGN_CHECK_EN.
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        stall
`ifdef DMEM_MISALIGN_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            mis_q;
  logic            mis_in;
  logic            accept;
  logic            access;
  logic [31:0]     mem [DEPTH];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign mis_in = |addr[1:0];
`else
  assign mis_in = 1'b0;
`endif

  // Upper address bits wrap; byte-offset bits matter only with the misalign check.
  logic unused_addr;
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

  assign accept = (state_q == StIdle) && req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StWait;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      mis_q   <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we;
        idx_q   <= addr[AW+1:2];
        wdata_q <= wdata;
        mis_q   <= mis_in;
      end
      if (access) begin
        if (mis_q) begin
          rdata <= 32'd0;
        end else if (!we_q) begin
          rdata <= mem[idx_q];
        end
      end
    end
  end

  // Array is not reset; an access aborted by reset never reaches StWait's final cycle.
  always_ff @(posedge clk) begin
    if (access && we_q && !mis_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign ready = (state_q == StResp);
  assign stall = req && !ready;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign err   = ready && mis_q;
`endif

endmodule
